// File: rtl/cart_bus_pkg.sv
// Shared types and default timing for the cartridge bus controller.
package cart_bus_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } cart_state_t;

    localparam int unsigned DEF_ADDR_W       = 16;
    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_SETUP_CYC    = 2;
    localparam int unsigned DEF_STROBE_CYC   = 4;
    localparam int unsigned DEF_RST_HOLD_CYC = 16777215;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cart_bus_ctrl_if.sv
// Core-side request/response bundle between the boy core and cart_bus_ctrl.
interface cart_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) ();

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_ready;
    logic [DATA_W-1:0] core_rdata;
    logic              core_rvalid;

    modport master (
        output core_req,
        output core_we,
        output core_addr,
        output core_wdata,
        input  core_ready,
        input  core_rdata,
        input  core_rvalid
    );

    modport slave (
        input  core_req,
        input  core_we,
        input  core_addr,
        input  core_wdata,
        output core_ready,
        output core_rdata,
        output core_rvalid
    );

endinterface

// File: rtl/cart_bus_ctrl_rst_seq.sv
// Cartridge reset sequencer: holds cart_rst_n low for RST_HOLD_CYC cycles
// after rst_n release or the last cycle of ext_reset.
module cart_rst_seq #(
    parameter int unsigned RST_HOLD_CYC = 16777215
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ext_reset,
    output logic hold_done,
    output logic cart_rst_n
);

    localparam int unsigned CNT_W = $clog2(RST_HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_HOLD_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            cart_rst_n <= 1'b0;
        end else if (ext_reset) begin
            cnt        <= '0;
            cart_rst_n <= 1'b0;
        end else if (!cart_rst_n) begin
            if (cnt == CNT_LAST) begin
                cart_rst_n <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Same-edge signal so the bus FSM leaves RST_HOLD exactly when cart_rst_n rises.
    assign hold_done = !cart_rst_n && (cnt == CNT_LAST);

endmodule

// File: rtl/cart_bus_ctrl.sv
// Registered bus-cycle engine between the core memory port and cartridge pins,
// with programmable setup/strobe timing and a sequenced cartridge reset.
module cart_bus_ctrl
    import cart_bus_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned SETUP_CYC    = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC   = DEF_STROBE_CYC,
    parameter int unsigned RST_HOLD_CYC = DEF_RST_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_reset,
    cart_bus_ctrl_if.slave    core,
    output logic [ADDR_W-1:0] cart_addr,
    output logic [DATA_W-1:0] cart_dout,
    output logic              cart_doe,
    input  logic [DATA_W-1:0] cart_din,
    output logic              cart_rd_n,
    output logic              cart_wr_n,
    output logic              cart_rst_n
);

    localparam int unsigned PH_MAX = max_u(SETUP_CYC, STROBE_CYC);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] SETUP_LAST  = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] STROBE_LAST = PH_W'(STROBE_CYC - 1);

    generate
        if (SETUP_CYC < 1 || STROBE_CYC < 1 || RST_HOLD_CYC < 1) begin : g_bad_param
            $error("cart_bus_ctrl: SETUP_CYC, STROBE_CYC and RST_HOLD_CYC must be >= 1");
        end
    endgenerate

    cart_state_t       state;
    logic [PH_W-1:0]   ph_cnt;
    logic              we_q;
    logic              ready_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              hold_done;

    cart_rst_seq #(
        .RST_HOLD_CYC (RST_HOLD_CYC)
    ) u_rst_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .ext_reset  (ext_reset),
        .hold_done  (hold_done),
        .cart_rst_n (cart_rst_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_HOLD;
            ph_cnt    <= '0;
            we_q      <= 1'b0;
            cart_addr <= '0;
            cart_dout <= '0;
            cart_doe  <= 1'b0;
            cart_rd_n <= 1'b1;
            cart_wr_n <= 1'b1;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else if (ext_reset) begin
            // Abort: address/data pins and last read data are left as they were.
            state     <= RST_HOLD;
            ph_cnt    <= '0;
            cart_doe  <= 1'b0;
            cart_rd_n <= 1'b1;
            cart_wr_n <= 1'b1;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state)
                RST_HOLD: begin
                    if (hold_done) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (core.core_req) begin
                        state     <= SETUP;
                        ph_cnt    <= SETUP_LAST;
                        we_q      <= core.core_we;
                        cart_addr <= core.core_addr;
                        cart_dout <= core.core_wdata;
                        cart_doe  <= core.core_we;
                        ready_q   <= 1'b0;
                    end
                end
                SETUP: begin
                    if (ph_cnt == '0) begin
                        state     <= STROBE;
                        ph_cnt    <= STROBE_LAST;
                        cart_rd_n <= we_q;
                        cart_wr_n <= !we_q;
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end
                end
                STROBE: begin
                    if (ph_cnt == '0) begin
                        state     <= HOLD;
                        cart_rd_n <= 1'b1;
                        cart_wr_n <= 1'b1;
                        if (!we_q) begin
                            rdata_q  <= cart_din;
                            rvalid_q <= 1'b1;
                        end
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end
                end
                HOLD: begin
                    state    <= IDLE;
                    cart_doe <= 1'b0;
                    ready_q  <= 1'b1;
                end
                default: begin
                    state     <= RST_HOLD;
                    cart_doe  <= 1'b0;
                    cart_rd_n <= 1'b1;
                    cart_wr_n <= 1'b1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign core.core_ready  = ready_q;
    assign core.core_rvalid = rvalid_q;
    assign core.core_rdata  = rdata_q;

endmodule
